// File: rtl/param_stack.sv
// param_stack: parametrised LIFO for the backtracking datapaths.
// Holds up to DEPTH words of WIDTH bits. It supports push, pop, and a
// same-cycle push+pop that replaces the top entry. It provides sticky
// overflow/underflow flags, a synchronous clear, a combinational peek at any
// depth below the top, and a high-water mark of the occupancy.
module param_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic [IW-1:0]    peek_index,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    max_count
);

  // Storage and control state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    max_q;
  logic             ovf_q;
  logic             unf_q;

  // Next-state decode
  logic [CW-1:0]    cnt_d;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic             ovf_set;
  logic             unf_set;

  // Read-side helpers
  logic             is_empty;
  logic             is_full;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    peek_pos;

  // High-water tracking: keep the larger of the stored mark and the new count.
  function automatic logic [CW-1:0] high_water(input logic [CW-1:0] mark,
                                               input logic [CW-1:0] next_cnt);
    return (next_cnt > mark) ? next_cnt : mark;
  endfunction

  // Occupancy decode; count never leaves [0, DEPTH], so equality tests suffice.
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));

  // Index of the top entry. This is meaningless when empty, so every user
  // gates it with is_empty.
  assign top_idx  = IW'(cnt_q - CW'(1));

  // Entry peek_index positions below the top. This is only read when
  // peek_valid is set, so the wrap for an out-of-range index is harmless.
  assign peek_pos = IW'(cnt_q - CW'(1) - CW'(peek_index));

  // Operation decode: replace-top, push, pop, or hold, with refusals at the bounds.
  always_comb begin
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push && pop && !is_empty) begin
      // Replace-top: overwrite in place. This is legal even when full.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      // A plain push, or push+pop on an empty stack, which acts as a push.
      if (!is_full) begin
        wr_en  = 1'b1;
        wr_idx = IW'(cnt_q);
        cnt_d  = cnt_q + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // Control registers. Clear zeroes occupancy, flags and the high-water mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= high_water(max_q, cnt_d);
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  // Entry storage. Only the addressed entry is written. Pops never erase data.
  // Clear leaves the memory contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !clear) begin
      mem[wr_idx] <= data_in;
    end
  end

  // Combinational read ports: top of stack and peek, both zero when invalid.
  always_comb begin
    data_out   = '0;
    peek_data  = '0;
    peek_valid = (CW'(peek_index) < cnt_q);
    if (!is_empty) begin
      data_out = mem[top_idx];
    end
    if (peek_valid) begin
      peek_data = mem[peek_pos];
    end
  end

  assign count     = cnt_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign max_count = max_q;

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for param_stack. Stimulus queues the
// expected post-edge state. Per-instance monitors pop and compare at the
// falling edge, or immediately on chk_ev for checks taken between edges.
module tb_param_stack;

  typedef struct {
    string name;
    int    cnt;
    int    dout;
    int    pv;
    int    pd;
    int    ovf;
    int    unf;
    int    maxc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  exp_t q0[$];
  exp_t q1[$];
  event chk_ev;

  // Instance 0: WIDTH=6, DEPTH=8
  logic       reset0, clear0, push0, pop0;
  logic [5:0] din0;
  logic [2:0] pidx0;
  logic [5:0] dout0, pdat0;
  logic       pv0, empty0, full0, ovf0, unf0;
  logic [3:0] cnt0, max0;

  // Instance 1: WIDTH=3, DEPTH=5
  logic       reset1, clear1, push1, pop1;
  logic [2:0] din1;
  logic [2:0] pidx1;
  logic [2:0] dout1, pdat1;
  logic       pv1, empty1, full1, ovf1, unf1;
  logic [2:0] cnt1, max1;

  param_stack #(.WIDTH(6), .DEPTH(8)) dut0 (
    .clk(clk), .reset(reset0), .clear(clear0), .push(push0), .pop(pop0),
    .data_in(din0), .peek_index(pidx0), .data_out(dout0), .peek_data(pdat0),
    .peek_valid(pv0), .count(cnt0), .empty(empty0), .full(full0),
    .overflow(ovf0), .underflow(unf0), .max_count(max0)
  );

  param_stack #(.WIDTH(3), .DEPTH(5)) dut1 (
    .clk(clk), .reset(reset1), .clear(clear1), .push(push1), .pop(pop1),
    .data_in(din1), .peek_index(pidx1), .data_out(dout1), .peek_data(pdat1),
    .peek_valid(pv1), .count(cnt1), .empty(empty1), .full(full1),
    .overflow(ovf1), .underflow(unf1), .max_count(max1)
  );

  // A negative expected value means "don't care".
  function automatic void cmp(input string n, input string f, input int act, input int exp);
    if (exp < 0) return;
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, exp);
  endfunction

  function automatic void check_all(input exp_t e, input int depth, input int c, input int d,
                                    input int v, input int p, input int o, input int u,
                                    input int m, input int em, input int fl);
    cmp(e.name, "count", c, e.cnt);
    cmp(e.name, "data_out", d, e.dout);
    cmp(e.name, "peek_valid", v, e.pv);
    cmp(e.name, "peek_data", p, e.pd);
    cmp(e.name, "overflow", o, e.ovf);
    cmp(e.name, "underflow", u, e.unf);
    cmp(e.name, "max_count", m, e.maxc);
    if (e.cnt >= 0) begin
      cmp(e.name, "empty", em, (e.cnt == 0) ? 1 : 0);
      cmp(e.name, "full", fl, (e.cnt == depth) ? 1 : 0);
    end
  endfunction

  // Monitor for instance 0
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q0.size() > 0) begin
        e = q0.pop_front();
        check_all(e, 8, int'(cnt0), int'(dout0), int'(pv0), int'(pdat0), int'(ovf0),
                  int'(unf0), int'(max0), int'(empty0), int'(full0));
      end
    end
  end

  // Monitor for instance 1
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q1.size() > 0) begin
        e = q1.pop_front();
        check_all(e, 5, int'(cnt1), int'(dout1), int'(pv1), int'(pdat1), int'(ovf1),
                  int'(unf1), int'(max1), int'(empty1), int'(full1));
      end
    end
  end

  function automatic exp_t mk(input string n, input int c, input int d, input int v,
                              input int p, input int o, input int u, input int m);
    exp_t e;
    e.name = n; e.cnt = c; e.dout = d; e.pv = v; e.pd = p;
    e.ovf = o; e.unf = u; e.maxc = m;
    return e;
  endfunction

  // One cycle on instance 0: drive, take the edge, queue the expectation,
  // then move off the falling edge.
  task automatic step0(input bit c, input bit pu, input bit po, input int d, input int pi,
                       input string n, input int ec, input int ed, input int epv,
                       input int epd, input int eov, input int eun, input int emx);
    clear0 = c; push0 = pu; pop0 = po; din0 = 6'(d); pidx0 = 3'(pi);
    @(posedge clk);
    q0.push_back(mk(n, ec, ed, epv, epd, eov, eun, emx));
    @(negedge clk);
    #1;
  endtask

  // Reference model for instance 1
  int  m_cnt, m_max, m_ovf, m_unf;
  int  m_mem[5];

  task automatic model1(input bit c, input bit pu, input bit po, input int d);
    if (c) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0; m_max = 0;
    end else begin
      if (pu && po && m_cnt > 0) m_mem[m_cnt-1] = d;
      else if (pu) begin
        if (m_cnt < 5) begin m_mem[m_cnt] = d; m_cnt++; end
        else m_ovf = 1;
      end else if (po) begin
        if (m_cnt > 0) m_cnt--;
        else m_unf = 1;
      end
      if (m_cnt > m_max) m_max = m_cnt;
    end
  endtask

  task automatic step1(input bit c, input bit pu, input bit po, input int d, input int pi,
                       input string n);
    int dv, vv, pd;
    clear1 = c; push1 = pu; pop1 = po; din1 = 3'(d); pidx1 = 3'(pi);
    @(posedge clk);
    model1(c, pu, po, d);
    dv = (m_cnt > 0) ? m_mem[m_cnt-1] : 0;
    vv = (pi < m_cnt) ? 1 : 0;
    pd = vv ? m_mem[m_cnt-1-pi] : 0;
    q1.push_back(mk(n, m_cnt, dv, vv, pd, m_ovf, m_unf, m_max));
    @(negedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset0 = 1'b1; clear0 = 1'b0; push0 = 1'b0; pop0 = 1'b0; din0 = '0; pidx0 = '0;
    reset1 = 1'b1; clear1 = 1'b0; push1 = 1'b0; pop1 = 1'b0; din1 = '0; pidx1 = '0;
    m_cnt = 0; m_max = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 5; i++) m_mem[i] = 0;

    repeat (2) @(negedge clk);
    #1;
    q0.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0));
    -> chk_ev;
    #1;
    reset0 = 1'b0;

    // Fill to full
    for (int i = 1; i <= 8; i++) step0(0, 1, 0, i, 0, "fill", i, i, 1, i, 0, 0, i);
    // Replace-top while full: no overflow
    step0(0, 1, 1, 42, 1, "repl_full", 8, 42, 1, 7, 0, 0, 8);
    // Push on full: refused, overflow set
    step0(0, 1, 0, 9, 0, "push_full", 8, 42, 1, 42, 1, 0, 8);
    // Deep peeks while holding
    step0(0, 0, 0, 0, 7, "peek_bot", 8, 42, 1, 1, 1, 0, 8);
    step0(0, 0, 0, 0, 3, "peek_mid", 8, 42, 1, 5, 1, 0, 8);
    // Drain
    for (int k = 1; k <= 8; k++)
      step0(0, 0, 1, 0, 0, "drain", 8 - k, 8 - k, (k < 8) ? 1 : 0, 8 - k, 1, 0, 8);
    step0(0, 0, 1, 0, 0, "pop_empty", 0, 0, 0, 0, 1, 1, 8);
    step0(0, 0, 0, 0, 0, "sticky", 0, 0, 0, 0, 1, 1, 8);
    // Clear wins over a push in the same cycle
    step0(1, 1, 0, 3, 0, "clear", 0, 0, 0, 0, 0, 0, 0);

    // Replace-top on a partially filled stack
    step0(0, 1, 0, 5, 0, "rt_p5", 1, 5, 1, 5, 0, 0, 1);
    step0(0, 1, 0, 6, 0, "rt_p6", 2, 6, 1, 6, 0, 0, 2);
    step0(0, 1, 1, 9, 1, "rt_pp", 2, 9, 1, 5, 0, 0, 2);
    step0(1, 0, 0, 0, 0, "clear2", 0, 0, 0, 0, 0, 0, 0);
    step0(0, 1, 1, 3, 0, "pp_empty", 1, 3, 1, 3, 0, 0, 1);
    step0(1, 0, 0, 0, 0, "clear3", 0, 0, 0, 0, 0, 0, 0);

    // Peek
    step0(0, 1, 0, 10, 0, "pk_p10", 1, 10, 1, 10, 0, 0, 1);
    step0(0, 1, 0, 20, 0, "pk_p20", 2, 20, 1, 20, 0, 0, 2);
    step0(0, 1, 0, 30, 0, "pk_p30", 3, 30, 1, 30, 0, 0, 3);
    step0(0, 0, 0, 0, 0, "peek0", 3, 30, 1, 30, 0, 0, 3);
    step0(0, 0, 0, 0, 1, "peek1", 3, 30, 1, 20, 0, 0, 3);
    step0(0, 0, 0, 0, 2, "peek2", 3, 30, 1, 10, 0, 0, 3);
    step0(0, 0, 0, 0, 3, "peek3", 3, 30, 0, 0, 0, 0, 3);
    step0(1, 0, 0, 0, 0, "clear4", 0, 0, 0, 0, 0, 0, 0);

    // Async reset between edges with push held
    for (int i = 1; i <= 4; i++) step0(0, 1, 0, i, 0, "ar_fill", i, i, 1, i, 0, 0, i);
    push0 = 1'b1; din0 = 6'd11; pidx0 = 3'd0;
    reset0 = 1'b1;
    #1;
    q0.push_back(mk("async_reset", 0, 0, 0, 0, 0, 0, 0));
    -> chk_ev;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset0 = 1'b0;
    step0(0, 1, 0, 7, 0, "post_reset", 1, 7, 1, 7, 0, 0, 1);

    // Non-power-of-two depth: fill to full, then overflow
    @(negedge clk);
    #1;
    reset1 = 1'b0;
    for (int i = 1; i <= 6; i++) step1(0, 1, 0, i, 0, "d5_fill");
    // Random run against the reference model
    for (int n = 0; n < 1000; n++) begin
      bit c, pu, po;
      int d, pi;
      c  = ($urandom_range(99) < 3);
      pu = ($urandom_range(99) < 55);
      po = ($urandom_range(99) < 50);
      d  = int'($urandom_range(7));
      pi = int'($urandom_range(7));
      step1(c, pu, po, d, pi, "rand");
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
